// File: rtl/glitchless_pkg.sv
// Shared types and helpers for the glitchless read-cycle controller.
// State values are the binary encoding; one-hot builds use the index localparams.
package glitchless_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DLY  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int OH_IDLE = 0;
  localparam int OH_READ = 1;
  localparam int OH_DLY  = 2;
  localparam int OH_DONE = 3;

  // {rd, ds} for a given state; the caller feeds it the next state so both strobes come straight from flops.
  function automatic logic [1:0] out_decode(state_e s);
    logic [1:0] o;
    o = 2'b00;
    case (s)
      READ, DLY: o = 2'b10;
      DONE:      o = 2'b01;
      default:   o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/glitchless.sv
// Four-state read-cycle controller with glitch-free registered rd/ds strobes.
// Supports binary (2-bit) or one-hot (4-bit) state encoding with identical timing.
module glitchless
  import glitchless_pkg::*;
#(
  parameter bit ONEHOT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic ws,
  output logic rd,
  output logic ds
);

  localparam int SW = ONEHOT ? 4 : 2;

  logic [SW-1:0] state_q, state_d;
  state_e        cur, nxt;
  logic          legal;
  logic          rd_q, ds_q;

  // Encoding-specific decode of the register and encode of the next state.
  if (ONEHOT) begin : g_onehot
    always_comb begin
      cur   = IDLE;
      legal = 1'b1;
      case (state_q)
        4'(1) << OH_IDLE: cur = IDLE;
        4'(1) << OH_READ: cur = READ;
        4'(1) << OH_DLY:  cur = DLY;
        4'(1) << OH_DONE: cur = DONE;
        default:          legal = 1'b0;
      endcase
    end

    always_comb begin
      state_d = '0;
      case (nxt)
        READ:    state_d[OH_READ] = 1'b1;
        DLY:     state_d[OH_DLY]  = 1'b1;
        DONE:    state_d[OH_DONE] = 1'b1;
        default: state_d[OH_IDLE] = 1'b1;
      endcase
    end
  end else begin : g_binary
    always_comb begin
      cur   = state_e'(state_q);
      legal = 1'b1;
    end

    always_comb begin
      state_d = nxt;
    end
  end

  // Any corrupted code falls back to IDLE on the next edge.
  always_comb begin
    nxt = IDLE;
    if (legal) begin
      case (cur)
        IDLE:    nxt = go ? READ : IDLE;
        READ:    nxt = DLY;
        DLY:     nxt = ws ? READ : DONE;
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ONEHOT ? SW'(1 << OH_IDLE) : SW'(IDLE);
      rd_q    <= 1'b0;
      ds_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      {rd_q, ds_q} <= out_decode(nxt);
    end
  end

  assign rd = rd_q;
  assign ds = ds_q;

endmodule

// File: tb/tb_glitchless.sv
// Bench for glitchless: both encodings run side by side against a transaction-level model.
module tb_glitchless;

  logic clk, reset, go, ws;
  logic rd0, ds0, rd1, ds1;

  int vectors = 0;
  int errors  = 0;

  // Reference model: number of rd cycles elapsed in the current transaction, plus a done flag.
  int   m_cnt  = 0;
  logic m_done = 1'b0;

  realtime t_pos = 0.0;

  glitchless #(.ONEHOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .go(go), .ws(ws), .rd(rd0), .ds(ds0)
  );
  glitchless #(.ONEHOT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .go(go), .ws(ws), .rd(rd1), .ds(ds1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) t_pos = $realtime;

  // Strobes may only move at a rising edge.
  always @(rd0 or ds0 or rd1 or ds1) begin
    if ($realtime != t_pos && $realtime > 0) begin
      errors++;
      $display("FAIL edge_only: strobe changed at %0t, last rising edge %0t", $realtime, t_pos);
    end
  end

  task automatic step(input logic g, input logic w, input logic r);
    logic exp_rd, exp_ds;
    logic [1:0] exp_st;
    go = g; ws = w; reset = r;
    @(posedge clk);
    // A read: go starts it; rd holds for pairs of cycles, extended while ws is seen on the even ones.
    if (r) begin
      m_cnt = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_cnt == 0) begin
      if (g) m_cnt = 1;
    end else if (m_cnt % 2 == 1) begin
      m_cnt++;
    end else if (w) begin
      m_cnt++;
    end else begin
      m_cnt = 0; m_done = 1'b1;
    end
    exp_rd = (m_cnt != 0);
    exp_ds = m_done;
    exp_st = m_done ? 2'd3 : (m_cnt == 0) ? 2'd0 : (m_cnt % 2 == 1) ? 2'd1 : 2'd2;
    #1;
    vectors++;
    if (rd0 !== exp_rd) begin
      errors++; $display("FAIL rd_bin: got %b exp %b at %0t", rd0, exp_rd, $realtime);
    end
    vectors++;
    if (ds0 !== exp_ds) begin
      errors++; $display("FAIL ds_bin: got %b exp %b at %0t", ds0, exp_ds, $realtime);
    end
    vectors++;
    if (rd1 !== exp_rd) begin
      errors++; $display("FAIL rd_onehot: got %b exp %b at %0t", rd1, exp_rd, $realtime);
    end
    vectors++;
    if (ds1 !== exp_ds) begin
      errors++; $display("FAIL ds_onehot: got %b exp %b at %0t", ds1, exp_ds, $realtime);
    end
    vectors++;
    if (dut0.state_q !== exp_st) begin
      errors++; $display("FAIL state_bin: got %0d exp %0d at %0t", dut0.state_q, exp_st, $realtime);
    end
    vectors++;
    if ((rd0 & ds0) !== 1'b0 || (rd1 & ds1) !== 1'b0) begin
      errors++; $display("FAIL rd_ds_overlap: bin %b%b onehot %b%b at %0t", rd0, ds0, rd1, ds1, $realtime);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_single_read();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wait_states();
    int rd_cycles;
    rd_cycles = 0;
    step(1'b1, 1'b0, 1'b0);
    rd_cycles += int'(rd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0);
      rd_cycles += int'(rd0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      rd_cycles += int'(rd0);
    end
    vectors++;
    if (rd_cycles != 8) begin
      errors++; $display("FAIL wait_rd_len: got %0d exp 8", rd_cycles);
    end
  endtask

  task automatic test_stuck_wait();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(31) == 0));
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; ws = 1'b0;
    test_reset();
    test_single_read();
    test_wait_states();
    test_stuck_wait();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
